// File: rtl/shift_add_mul_ctrl_pkg.sv
// Shared encodings for the shift-add multiplier controller and its datapath.
// Shift codes follow the ShiftRL register convention: 00 hold, 10 right, 01 left.
package shift_add_mul_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TEST,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [1:0] SHIFT_HOLD  = 2'b00;
  localparam logic [1:0] SHIFT_RIGHT = 2'b10;
  localparam logic [1:0] SHIFT_LEFT  = 2'b01;

  typedef struct packed {
    logic       load_en;
    logic       clr_a;
    logic       add_en;
    logic [1:0] shift_a;
    logic [1:0] shift_q;
    logic       busy;
    logic       done;
  } ctrl_t;

  // Moore decode: strobes implied by the state being entered.
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c         = '0;
    c.shift_a = SHIFT_HOLD;
    c.shift_q = SHIFT_HOLD;
    c.busy    = (s != S_IDLE);
    unique case (s)
      S_LOAD: begin
        c.load_en = 1'b1;
        c.clr_a   = 1'b1;
      end
      S_ADD:   c.add_en = 1'b1;
      S_SHIFT: begin
        c.shift_a = SHIFT_RIGHT;
        c.shift_q = SHIFT_RIGHT;
      end
      S_DONE:  c.done = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mul_step_counter.sv
// Shift-step counter: counts completed shifts, saturating at WIDTH.
// last flags the step whose increment reaches WIDTH; tc flags WIDTH itself.
module mul_step_counter #(
  parameter int WIDTH = 8
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic                       clr,
  input  logic                       inc,
  output logic [$clog2(WIDTH+1)-1:0] step,
  output logic                       last,
  output logic                       tc
);

  localparam int SW = $clog2(WIDTH + 1);

  // Clear wins over increment; never wraps past WIDTH.
  always_ff @(posedge CLK) begin
    if (Reset || clr)
      step <= '0;
    else if (inc && !tc)
      step <= step + SW'(1);
  end

  assign tc   = (step == SW'(WIDTH));
  assign last = (step == SW'(WIDTH - 1));

endmodule

// File: rtl/shift_add_mul_ctrl.sv
// Controller for a shift-add multiplier: LOAD, then WIDTH x (TEST [ADD] SHIFT).
// Build with MUL_CTRL_BUSY_ERR_EN to flag Start while busy on a sticky Err.
module shift_add_mul_ctrl
  import shift_add_mul_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic                       Start,
  input  logic                       Ack,
  input  logic                       Q0,
  output logic                       LoadEn,
  output logic                       ClrA,
  output logic                       AddEn,
  output logic [1:0]                 ShiftA,
  output logic [1:0]                 ShiftQ,
  output logic                       Busy,
  output logic                       Done,
  output logic [$clog2(WIDTH+1)-1:0] Step,
  output logic                       Err
);

  state_t state;
  state_t nxt;
  ctrl_t  ctl;
  logic   clr;
  logic   inc;
  logic   last;
  logic   tc;

  // Step is cleared while loading and when a result is acknowledged.
  assign clr = (state == S_LOAD) || (state == S_DONE && Ack);
  assign inc = (state == S_SHIFT) && !tc;

  mul_step_counter #(
    .WIDTH(WIDTH)
  ) u_step (
    .CLK  (CLK),
    .Reset(Reset),
    .clr  (clr),
    .inc  (inc),
    .step (Step),
    .last (last),
    .tc   (tc)
  );

  // Next-state: Start only heard in IDLE, Ack only in DONE.
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (Start) nxt = S_LOAD;
      S_LOAD:  nxt = S_TEST;
      S_TEST:  nxt = Q0 ? S_ADD : S_SHIFT;
      S_ADD:   nxt = S_SHIFT;
      S_SHIFT: nxt = last ? S_DONE : S_TEST;
      S_DONE:  if (Ack) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // State and registered Moore outputs decoded from the next state.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= S_IDLE;
      ctl   <= '0;
    end else begin
      state <= nxt;
      ctl   <= decode(nxt);
    end
  end

  assign LoadEn = ctl.load_en;
  assign ClrA   = ctl.clr_a;
  assign AddEn  = ctl.add_en;
  assign ShiftA = ctl.shift_a;
  assign ShiftQ = ctl.shift_q;
  assign Busy   = ctl.busy;
  assign Done   = ctl.done;

`ifdef MUL_CTRL_BUSY_ERR_EN
  logic err_q;

  // Sticky: Start seen while busy; an acknowledged DONE is not busy.
  always_ff @(posedge CLK) begin
    if (Reset)
      err_q <= 1'b0;
    else if (Start && state != S_IDLE && !(state == S_DONE && Ack))
      err_q <= 1'b1;
  end

  assign Err = err_q;
`else
  assign Err = 1'b0;
`endif

endmodule
